// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin arbiter and sequencer that lets the
// instruction-fetch port and the data load/store port share one
// memory_block. Each granted request runs IDLE -> ACCESS -> RESP.
module mem_port_arbiter #(
   parameter int ADDR_W = 18,
   parameter int DATA_W = 32,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_ack,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic              d_byte,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_ack,
   output logic [DATA_W-1:0] d_rdata,
   output logic [ADDR_W-1:0] mem_address,
   output logic [DATA_W-1:0] mem_write_data,
   output logic              mem_byteOperations,
   output logic              mem_memRead,
   output logic              mem_memWrite,
   input  logic [DATA_W-1:0] mem_read_data,
   output logic [CNT_W-1:0]  if_grants,
   output logic [CNT_W-1:0]  d_grants
);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   localparam logic OWN_IF = 1'b0;
   localparam logic OWN_D  = 1'b1;

   state_t            state_q, state_d;
   logic              owner_q, owner_d;   // current owner, doubles as last_owner
   logic              grant_d_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              we_q, we_d;
   logic              byte_q, byte_d;
   logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
   logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
   logic [CNT_W-1:0]  if_cnt_q, if_cnt_d;
   logic [CNT_W-1:0]  d_cnt_q, d_cnt_d;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
   endfunction

   function automatic logic [DATA_W-1:0] zext_byte(input logic [DATA_W-1:0] v);
      return {{(DATA_W-8){1'b0}}, v[7:0]};
   endfunction

   // Control state, read-back registers and counters; all cleared by reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         owner_q    <= OWN_IF;
         if_rdata_q <= '0;
         d_rdata_q  <= '0;
         if_cnt_q   <= '0;
         d_cnt_q    <= '0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         if_rdata_q <= if_rdata_d;
         d_rdata_q  <= d_rdata_d;
         if_cnt_q   <= if_cnt_d;
         d_cnt_q    <= d_cnt_d;
      end
   end

   // Latched request fields; only observed while in ACCESS, so no reset needed.
   always_ff @(posedge clk) begin
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      byte_q  <= byte_d;
   end

   // Next-state logic: arbitrate in IDLE, capture read data in ACCESS, count in RESP.
   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      grant_d_d  = 1'b0;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      we_d       = we_q;
      byte_d     = byte_q;
      if_rdata_d = if_rdata_q;
      d_rdata_d  = d_rdata_q;
      if_cnt_d   = if_cnt_q;
      d_cnt_d    = d_cnt_q;
      case (state_q)
         IDLE: begin
            if (if_req || d_req) begin
               // Data wins when alone, or on a tie when IF owned last.
               grant_d_d = d_req && (!if_req || (owner_q == OWN_IF));
               owner_d   = grant_d_d ? OWN_D : OWN_IF;
               if (grant_d_d) begin
                  addr_d  = d_addr;
                  wdata_d = d_wdata;
                  we_d    = d_we;
                  byte_d  = d_byte;
               end else begin
                  addr_d  = if_addr;
                  wdata_d = '0;
                  we_d    = 1'b0;
                  byte_d  = 1'b0;
               end
               state_d = ACCESS;
            end
         end
         ACCESS: begin
            if (!we_q) begin
               if (owner_q == OWN_D) begin
                  d_rdata_d = byte_q ? zext_byte(mem_read_data) : mem_read_data;
               end else begin
                  if_rdata_d = mem_read_data;
               end
            end
            state_d = RESP;
         end
         RESP: begin
            if (owner_q == OWN_D) begin
               d_cnt_d = sat_inc(d_cnt_q);
            end else begin
               if_cnt_d = sat_inc(if_cnt_q);
            end
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Memory controls are decoded from state, so requests never reach them combinationally.
   always_comb begin
      mem_address        = '0;
      mem_write_data     = '0;
      mem_byteOperations = 1'b0;
      mem_memRead        = 1'b0;
      mem_memWrite       = 1'b0;
      if (state_q == ACCESS) begin
         mem_address        = addr_q;
         mem_write_data     = wdata_q;
         mem_byteOperations = byte_q;
         mem_memRead        = !we_q;
         mem_memWrite       = we_q;
      end
   end

   assign if_ack    = (state_q == RESP) && (owner_q == OWN_IF);
   assign d_ack     = (state_q == RESP) && (owner_q == OWN_D);
   assign if_rdata  = if_rdata_q;
   assign d_rdata   = d_rdata_q;
   assign if_grants = if_cnt_q;
   assign d_grants  = d_cnt_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a word memory model behind the main instance,
// a second instance with 2-bit counters for saturation, and a scoreboard of
// expected read-back values popped on every ack.
module tb_mem_port_arbiter;

   localparam int ADDR_W = 18;
   localparam int DATA_W = 32;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              reset = 1'b1;
   logic              if_req = 1'b0;
   logic [ADDR_W-1:0] if_addr = '0;
   logic              if_ack;
   logic [DATA_W-1:0] if_rdata;
   logic              d_req = 1'b0;
   logic              d_we = 1'b0;
   logic              d_byte = 1'b0;
   logic [ADDR_W-1:0] d_addr = '0;
   logic [DATA_W-1:0] d_wdata = '0;
   logic              d_ack;
   logic [DATA_W-1:0] d_rdata;
   logic [ADDR_W-1:0] mem_address;
   logic [DATA_W-1:0] mem_write_data;
   logic              mem_byteOperations;
   logic              mem_memRead;
   logic              mem_memWrite;
   logic [DATA_W-1:0] mem_read_data;
   logic [15:0]       if_grants;
   logic [15:0]       d_grants;

   // Saturation instance signals
   logic              s_if_req = 1'b0;
   logic [ADDR_W-1:0] s_if_addr = 18'd3;
   logic              s_if_ack;
   logic [DATA_W-1:0] s_if_rdata;
   logic              s_d_req = 1'b0;
   logic              s_d_we = 1'b0;
   logic              s_d_byte = 1'b0;
   logic [ADDR_W-1:0] s_d_addr = '0;
   logic [DATA_W-1:0] s_d_wdata = '0;
   logic              s_d_ack;
   logic [DATA_W-1:0] s_d_rdata;
   logic [ADDR_W-1:0] s_mem_address;
   logic [DATA_W-1:0] s_mem_write_data;
   logic              s_mem_byteOperations;
   logic              s_mem_memRead;
   logic              s_mem_memWrite;
   logic [DATA_W-1:0] s_mem_read_data = 32'h12345678;
   logic [1:0]        s_if_grants;
   logic [1:0]        s_d_grants;

   mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(16)) dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
      .d_req(d_req), .d_we(d_we), .d_byte(d_byte), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_ack(d_ack), .d_rdata(d_rdata),
      .mem_address(mem_address), .mem_write_data(mem_write_data),
      .mem_byteOperations(mem_byteOperations), .mem_memRead(mem_memRead),
      .mem_memWrite(mem_memWrite), .mem_read_data(mem_read_data),
      .if_grants(if_grants), .d_grants(d_grants)
   );

   mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(2)) sdut (
      .clk(clk), .reset(reset),
      .if_req(s_if_req), .if_addr(s_if_addr), .if_ack(s_if_ack), .if_rdata(s_if_rdata),
      .d_req(s_d_req), .d_we(s_d_we), .d_byte(s_d_byte), .d_addr(s_d_addr), .d_wdata(s_d_wdata),
      .d_ack(s_d_ack), .d_rdata(s_d_rdata),
      .mem_address(s_mem_address), .mem_write_data(s_mem_write_data),
      .mem_byteOperations(s_mem_byteOperations), .mem_memRead(s_mem_memRead),
      .mem_memWrite(s_mem_memWrite), .mem_read_data(s_mem_read_data),
      .if_grants(s_if_grants), .d_grants(s_d_grants)
   );

   // Memory model: asynchronous word read, byte stores replace the low byte.
   logic [31:0] mem [0:255];
   assign mem_read_data = mem[mem_address[7:0]];
   always @(posedge clk) begin
      if (mem_memWrite) begin
         if (mem_byteOperations) mem[mem_address[7:0]][7:0] <= mem_write_data[7:0];
         else                    mem[mem_address[7:0]]      <= mem_write_data;
      end
   end

   int compared = 0;
   int mismatched = 0;
   logic [31:0] if_exp[$];
   logic [31:0] d_exp[$];
   logic [31:0] last_d_exp = '0;

   // Scoreboard monitor and per-cycle invariants.
   always @(negedge clk) begin
      logic [31:0] e;
      if (!reset) begin
         compared++;
         if ((if_ack && d_ack) !== 1'b0) begin
            mismatched++; $display("FAIL both_ack: if_ack=%b d_ack=%b required not both", if_ack, d_ack);
         end
         compared++;
         if ((mem_memRead && mem_memWrite) !== 1'b0 || (s_mem_memRead && s_mem_memWrite) !== 1'b0) begin
            mismatched++; $display("FAIL rd_wr_exclusive: memRead=%b memWrite=%b", mem_memRead, mem_memWrite);
         end
         if (if_ack) begin
            compared++;
            if (if_exp.size() == 0) begin
               mismatched++; $display("FAIL if_ack_unexpected: if_rdata=%h required no ack", if_rdata);
            end else begin
               e = if_exp.pop_front();
               if (if_rdata !== e) begin
                  mismatched++; $display("FAIL if_rdata: got %h required %h", if_rdata, e);
               end
            end
         end
         if (d_ack) begin
            compared++;
            if (d_exp.size() == 0) begin
               mismatched++; $display("FAIL d_ack_unexpected: d_rdata=%h required no ack", d_rdata);
            end else begin
               e = d_exp.pop_front();
               if (d_rdata !== e) begin
                  mismatched++; $display("FAIL d_rdata: got %h required %h", d_rdata, e);
               end
            end
         end
      end
   end

   task automatic apply_reset();
      @(negedge clk); #1;
      reset = 1'b1; if_req = 1'b0; d_req = 1'b0; s_if_req = 1'b0;
      if_exp.delete(); d_exp.delete(); last_d_exp = '0;
      repeat (2) @(negedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic d_txn(input logic we, input logic byt, input logic [ADDR_W-1:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_load);
      bit seen = 0;
      if (we) d_exp.push_back(last_d_exp);
      else begin d_exp.push_back(exp_load); last_d_exp = exp_load; end
      d_req = 1'b1; d_we = we; d_byte = byt; d_addr = addr; d_wdata = wdata;
      for (int i = 0; i < 10 && !seen; i++) begin
         @(negedge clk);
         if (d_ack) seen = 1;
      end
      compared++;
      if (!seen) begin mismatched++; $display("FAIL d_txn_timeout: ack=0 required 1 (addr %0d)", addr); end
      d_req = 1'b0;
      @(negedge clk);
   endtask

   task automatic if_txn(input logic [ADDR_W-1:0] addr, input logic [31:0] exp);
      bit seen = 0;
      if_exp.push_back(exp);
      if_req = 1'b1; if_addr = addr;
      for (int i = 0; i < 10 && !seen; i++) begin
         @(negedge clk);
         if (if_ack) seen = 1;
      end
      compared++;
      if (!seen) begin mismatched++; $display("FAIL if_txn_timeout: ack=0 required 1 (addr %0d)", addr); end
      if_req = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      compared++;
      if ({if_ack, d_ack, mem_memRead, mem_memWrite, mem_byteOperations} !== 5'b0 ||
          mem_address !== '0 || mem_write_data !== '0) begin
         mismatched++; $display("FAIL reset_ctrl: ack/mem outputs nonzero addr=%h", mem_address);
      end
      compared++;
      if (if_rdata !== 32'h0 || d_rdata !== 32'h0 || if_grants !== 16'h0 || d_grants !== 16'h0) begin
         mismatched++; $display("FAIL reset_data: if_rdata=%h d_rdata=%h grants=%0d/%0d required 0",
                                if_rdata, d_rdata, if_grants, d_grants);
      end
      #1 reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_single_fetch();
      d_txn(1'b1, 1'b0, 18'd5, 32'hDEADBEEF, 32'h0);
      if_exp.push_back(32'hDEADBEEF);
      if_req = 1'b1; if_addr = 18'd5;
      @(negedge clk);
      compared++;
      if (mem_memRead !== 1'b1 || mem_memWrite !== 1'b0 || mem_address !== 18'd5) begin
         mismatched++; $display("FAIL fetch_access: memRead=%b memWrite=%b addr=%0d required 1/0/5",
                                mem_memRead, mem_memWrite, mem_address);
      end
      @(negedge clk);
      compared++;
      if (if_ack !== 1'b1 || mem_memRead !== 1'b0) begin
         mismatched++; $display("FAIL fetch_ack: if_ack=%b memRead=%b required 1/0", if_ack, mem_memRead);
      end
      if_req = 1'b0;
      @(negedge clk);
      compared++;
      if (if_grants !== 16'd1 || d_grants !== 16'd1) begin
         mismatched++; $display("FAIL fetch_grants: if=%0d d=%0d required 1/1", if_grants, d_grants);
      end
   endtask

   task automatic test_byte_store_load();
      d_txn(1'b1, 1'b0, 18'd7, 32'h11223300, 32'h0);
      d_exp.push_back(last_d_exp);
      d_req = 1'b1; d_we = 1'b1; d_byte = 1'b1; d_addr = 18'd7; d_wdata = 32'h000000A5;
      @(negedge clk);
      compared++;
      if (mem_memWrite !== 1'b1 || mem_memRead !== 1'b0 || mem_byteOperations !== 1'b1 ||
          mem_write_data !== 32'h000000A5) begin
         mismatched++; $display("FAIL bstore_access: memWrite=%b memRead=%b byte=%b wdata=%h required 1/0/1/a5",
                                mem_memWrite, mem_memRead, mem_byteOperations, mem_write_data);
      end
      @(negedge clk);
      compared++;
      if (d_ack !== 1'b1 || mem_memWrite !== 1'b0) begin
         mismatched++; $display("FAIL bstore_resp: d_ack=%b memWrite=%b required 1/0", d_ack, mem_memWrite);
      end
      d_req = 1'b0;
      @(negedge clk);
      d_txn(1'b0, 1'b1, 18'd7, 32'h0, 32'h000000A5);
      d_txn(1'b0, 1'b0, 18'd7, 32'h0, 32'h112233A5);
      compared++;
      if (d_grants !== 16'd5) begin
         mismatched++; $display("FAIL bstore_grants: d_grants=%0d required 5", d_grants);
      end
   endtask

   task automatic test_tie();
      int d_at = -1;
      int if_at = -1;
      apply_reset();
      if_exp.push_back(32'hDEADBEEF);
      d_exp.push_back(32'h112233A5); last_d_exp = 32'h112233A5;
      if_req = 1'b1; if_addr = 18'd5;
      d_req = 1'b1; d_we = 1'b0; d_byte = 1'b0; d_addr = 18'd7;
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         if (d_ack)  begin d_at = i;  d_req = 1'b0;  end
         if (if_ack) begin if_at = i; if_req = 1'b0; end
      end
      compared++;
      if (d_at !== 2 || if_at !== 5) begin
         mismatched++; $display("FAIL tie_order: d_ack at %0d if_ack at %0d required 2 and 5", d_at, if_at);
      end
   endtask

   task automatic test_contention();
      int nd = 0;
      int ni = 0;
      logic exp_d = 1'b1;
      apply_reset();
      for (int i = 0; i < 5; i++) begin
         if_exp.push_back(32'hDEADBEEF);
         d_exp.push_back(32'h000000A5);
      end
      last_d_exp = 32'h000000A5;
      if_req = 1'b1; if_addr = 18'd5;
      d_req = 1'b1; d_we = 1'b0; d_byte = 1'b1; d_addr = 18'd7;
      for (int i = 1; i <= 30; i++) begin
         @(negedge clk);
         if (d_ack || if_ack) begin
            compared++;
            if (d_ack !== exp_d) begin
               mismatched++; $display("FAIL contend_order: cycle %0d d_ack=%b required %b", i, d_ack, exp_d);
            end
            exp_d = ~exp_d;
            if (d_ack) nd++;
            if (if_ack) ni++;
         end
      end
      if_req = 1'b0; d_req = 1'b0;
      compared++;
      if (nd != 5 || ni != 5 || d_grants !== 16'd5 || if_grants !== 16'd5) begin
         mismatched++; $display("FAIL contend_count: acks d=%0d if=%0d grants d=%0d if=%0d required 5 each",
                                nd, ni, d_grants, if_grants);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid_access();
      d_req = 1'b1; d_we = 1'b1; d_byte = 1'b0; d_addr = 18'd9; d_wdata = 32'hCAFEF00D;
      @(negedge clk);
      compared++;
      if (mem_memWrite !== 1'b1) begin
         mismatched++; $display("FAIL midrst_access: memWrite=%b required 1", mem_memWrite);
      end
      #1 reset = 1'b1; d_req = 1'b0;
      @(negedge clk);
      compared++;
      if (mem_memWrite !== 1'b0 || mem_memRead !== 1'b0 || d_ack !== 1'b0 ||
          d_grants !== 16'd0 || if_grants !== 16'd0) begin
         mismatched++; $display("FAIL midrst_state: memWrite=%b d_ack=%b d_grants=%0d if_grants=%0d required 0",
                                mem_memWrite, d_ack, d_grants, if_grants);
      end
      #1 reset = 1'b0; last_d_exp = '0;
      @(negedge clk);
      if_txn(18'd5, 32'hDEADBEEF);
      compared++;
      if (if_grants !== 16'd1 || d_grants !== 16'd0) begin
         mismatched++; $display("FAIL midrst_after: if_grants=%0d d_grants=%0d required 1/0", if_grants, d_grants);
      end
   endtask

   task automatic test_saturation();
      logic [1:0] expg;
      for (int k = 1; k <= 5; k++) begin
         s_if_req = 1'b1;
         @(negedge clk);
         compared++;
         if (s_mem_memRead !== 1'b1 || s_mem_address !== 18'd3) begin
            mismatched++; $display("FAIL sat_access[%0d]: memRead=%b addr=%0d required 1/3", k, s_mem_memRead, s_mem_address);
         end
         @(negedge clk);
         compared++;
         if (s_if_ack !== 1'b1 || s_if_rdata !== 32'h12345678) begin
            mismatched++; $display("FAIL sat_ack[%0d]: ack=%b rdata=%h required 1/12345678", k, s_if_ack, s_if_rdata);
         end
         s_if_req = 1'b0;
         @(negedge clk);
         expg = (k > 3) ? 2'd3 : 2'(k);
         compared++;
         if (s_if_grants !== expg) begin
            mismatched++; $display("FAIL sat_count[%0d]: if_grants=%0d required %0d", k, s_if_grants, expg);
         end
      end
      compared++;
      if (s_d_grants !== 2'd0 || s_d_ack !== 1'b0 || s_d_rdata !== 32'h0 || s_mem_address !== '0 ||
          s_mem_write_data !== '0 || s_mem_byteOperations !== 1'b0 || s_mem_memWrite !== 1'b0) begin
         mismatched++; $display("FAIL sat_idle: d_grants=%0d d_rdata=%h addr=%h required all 0",
                                s_d_grants, s_d_rdata, s_mem_address);
      end
   endtask

   initial begin
      test_reset();
      test_single_fetch();
      test_byte_store_load();
      test_tie();
      test_contention();
      test_reset_mid_access();
      test_saturation();
      compared++;
      if (if_exp.size() != 0 || d_exp.size() != 0) begin
         mismatched++; $display("FAIL scoreboard_drain: pending if=%0d d=%0d required 0", if_exp.size(), d_exp.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
